// File: rtl/cam_pkg.sv
// ============================================================================
// cam_pkg : shared defaults and read-port state type for the CAM entry array
// Rev 1.0
// ============================================================================
`default_nettype none

package cam_pkg;

  localparam int unsigned CAM_DATA_WIDTH = 32;
  localparam int unsigned CAM_DEPTH      = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } cam_rd_state_e;

endpackage

`default_nettype wire

// File: rtl/cam_word_sel.sv
// ============================================================================
// cam_word_sel : combinational entry word / valid-bit selector with range guard
// Rev 1.0
// ============================================================================
`default_nettype none

module cam_word_sel
  import cam_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = CAM_DATA_WIDTH,
  parameter  int unsigned DEPTH      = CAM_DEPTH,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [DEPTH*DATA_WIDTH-1:0] all_data_i,
  input  logic [DEPTH-1:0]            entry_vld_i,
  input  logic [ADDR_WIDTH-1:0]       index_i,
  output logic [DATA_WIDTH-1:0]       word_o,
  output logic                        vld_o,
  output logic                        in_range_o
);

  logic [DATA_WIDTH-1:0] words [DEPTH];

  for (genvar e = 0; e < DEPTH; e++) begin : g_unpack
    assign words[e] = all_data_i[e*DATA_WIDTH +: DATA_WIDTH];
  end

  // Indices past DEPTH exist only for non-power-of-2 depths and read as empty.
  assign in_range_o = (32'(index_i) < DEPTH);

  always_comb begin
    word_o = '0;
    vld_o  = 1'b0;
    if (in_range_o) begin
      word_o = words[index_i];
      vld_o  = entry_vld_i[index_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/cam_read_port.sv
// ============================================================================
// cam_read_port : registered single/burst read port over the CAM entry array
// Rev 1.0
// ============================================================================
`default_nettype none

module cam_read_port
  import cam_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = CAM_DATA_WIDTH,
  parameter  int unsigned DEPTH      = CAM_DEPTH,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned SIZE       = DEPTH * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  input  logic                  req_burst_i,
  input  logic [ADDR_WIDTH-1:0] req_len_i,
  input  logic [SIZE-1:0]       all_data_i,
  input  logic [DEPTH-1:0]      entry_vld_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic                  rsp_last_o,
  output logic                  any_vld_o,
  output logic                  busy_o
);

  cam_rd_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  any_vld_q;

  logic                  slot_free;
  logic                  accept;
  logic                  load;
  logic                  beat_last;
  logic [ADDR_WIDTH-1:0] sel_index;
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  sel_vld;
  logic                  sel_in_range;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign slot_free   = !rsp_valid_q || rsp_ready_i;
  assign req_ready_o = !reset && (state_q == IDLE) && slot_free;
  assign accept      = req_valid_i && req_ready_o;
  assign sel_index   = (state_q == BURST) ? ptr_q : req_index_i;

  cam_word_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_word_sel (
    .all_data_i  (all_data_i),
    .entry_vld_i (entry_vld_i),
    .index_i     (sel_index),
    .word_o      (sel_word),
    .vld_o       (sel_vld),
    .in_range_o  (sel_in_range)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    rsp_last_d  = rsp_last_q;
    load        = 1'b0;
    beat_last   = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          // Out-of-range starts collapse to a single beat regardless of burst.
          if (req_burst_i && (req_len_i != '0) && sel_in_range) begin
            beat_last = 1'b0;
            state_d   = BURST;
            rem_d     = req_len_i;
            ptr_d     = next_ptr(req_index_i);
          end
        end
      end
      BURST: begin
        if (slot_free) begin
          load      = 1'b1;
          beat_last = (rem_q == ADDR_WIDTH'(1));
          ptr_d     = next_ptr(ptr_q);
          rem_d     = rem_q - ADDR_WIDTH'(1);
          if (beat_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sel_word;
      rsp_hit_d   = sel_vld;
      rsp_index_d = sel_index;
      rsp_last_d  = beat_last;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_last_q  <= 1'b0;
      any_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_last_q  <= rsp_last_d;
      any_vld_q   <= |entry_vld_i;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_index_o = rsp_index_q;
  assign rsp_last_o  = rsp_last_q;
  assign any_vld_o   = any_vld_q;
  assign busy_o      = (state_q == BURST);

endmodule

`default_nettype wire

// File: tb/tb_cam_read_port.sv
// ============================================================================
// tb_cam_read_port : directed + randomized bench for DEPTH=32 and DEPTH=20 ports
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cam_read_port;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1023:0] all_data;
  logic [31:0]   entry_vld;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [4:0]  req_index [2];
  logic        req_burst [2];
  logic [4:0]  req_len   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_hit   [2];
  logic [4:0]  rsp_index [2];
  logic        rsp_last  [2];
  logic        any_vld   [2];
  logic        busy      [2];

  int    checks   = 0;
  int    failures = 0;
  logic  mon_data_en = 1'b1;
  logic  rr_mode [2];
  beat_t expq [2][$];
  logic  hold_pend [2];
  beat_t hold_b [2];

  always #5 clk = ~clk;

  cam_read_port #(.DATA_WIDTH(32), .DEPTH(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_index_i(req_index[0]), .req_burst_i(req_burst[0]), .req_len_i(req_len[0]),
    .all_data_i(all_data), .entry_vld_i(entry_vld),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
    .rsp_hit_o(rsp_hit[0]), .rsp_index_o(rsp_index[0]), .rsp_last_o(rsp_last[0]),
    .any_vld_o(any_vld[0]), .busy_o(busy[0])
  );

  cam_read_port #(.DATA_WIDTH(32), .DEPTH(20)) u_dut20 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_index_i(req_index[1]), .req_burst_i(req_burst[1]), .req_len_i(req_len[1]),
    .all_data_i(all_data[639:0]), .entry_vld_i(entry_vld[19:0]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
    .rsp_hit_o(rsp_hit[1]), .rsp_index_o(rsp_index[1]), .rsp_last_o(rsp_last[1]),
    .any_vld_o(any_vld[1]), .busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 32 : 20;
  endfunction

  // Reference: a request expands into its full list of beats at acceptance.
  function automatic void model_push(input int d, input logic [4:0] idx,
                                     input logic burst, input logic [4:0] len);
    int    dep;
    int    n;
    int    cur;
    beat_t b;
    dep = depth_of(d);
    if (int'(idx) >= dep) begin
      b = '{32'h0, 1'b0, idx, 1'b1};
      expq[d].push_back(b);
    end else begin
      n = burst ? int'(len) + 1 : 1;
      for (int k = 0; k < n; k++) begin
        cur    = (int'(idx) + k) % dep;
        b.data = all_data[cur*32 +: 32];
        b.hit  = entry_vld[cur];
        b.idx  = cur[4:0];
        b.last = (k == n - 1);
        expq[d].push_back(b);
      end
    end
  endfunction

  always @(posedge clk) begin
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        expq[d].delete();
        hold_pend[d] = 1'b0;
      end else begin
        if (hold_pend[d])
          check("hold_stable", {rsp_valid[d], rsp_data[d], rsp_hit[d], rsp_index[d], rsp_last[d]},
                {1'b1, hold_b[d].data, hold_b[d].hit, hold_b[d].idx, hold_b[d].last});
        if (rsp_valid[d] && rsp_ready[d]) begin
          if (expq[d].size() == 0) begin
            check("unexpected_beat", {59'd0, rsp_index[d]}, 64'hFFFF);
          end else begin
            b = expq[d].pop_front();
            if (mon_data_en)
              check("beat", {rsp_data[d], rsp_hit[d], rsp_index[d], rsp_last[d]},
                    {b.data, b.hit, b.idx, b.last});
            else
              check("beat_idx", {rsp_index[d], rsp_last[d]}, {b.idx, b.last});
          end
        end
        if (req_valid[d] && req_ready[d])
          model_push(d, req_index[d], req_burst[d], req_len[d]);
        hold_pend[d] = rsp_valid[d] && !rsp_ready[d];
        hold_b[d]    = '{rsp_data[d], rsp_hit[d], rsp_index[d], rsp_last[d]};
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rr_mode[d]) rsp_ready[d] = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a request from the next falling edge until it is accepted.
  task automatic send(input int d, input logic [4:0] idx, input logic burst, input logic [4:0] len);
    logic acc;
    int   n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_index[d] = idx;
    req_burst[d] = burst;
    req_len[d]   = len;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      #1;
      acc = req_ready[d];
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_req(input int d);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((expq[d].size() != 0 || rsp_valid[d]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {63'd0, n < 3000}, 64'd1);
    check("leftover_beats", 64'(expq[d].size()), 64'd0);
  endtask

  task automatic randomize_entries();
    for (int e = 0; e < 32; e++) all_data[e*32 +: 32] = $urandom;
    entry_vld = $urandom;
  endtask

  initial begin
    logic [31:0] old8;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_index[d] = '0; req_burst[d] = 1'b0; req_len[d] = '0;
      rsp_ready[d] = 1'b1; rr_mode[d] = 1'b0; hold_pend[d] = 1'b0;
    end
    reset = 1'b1;
    all_data = '0;
    entry_vld = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, req_ready[0]}, 64'd0);
    check("rst_outs", {rsp_valid[0], rsp_data[0], rsp_hit[0], rsp_index[0], rsp_last[0], any_vld[0], busy[0]}, 64'd0);
    check("rst_outs20", {rsp_valid[1], any_vld[1], busy[1]}, 64'd0);
    randomize_entries();
    reset = 1'b0;
    tick();

    // Single read of entry 3
    all_data[3*32 +: 32] = 32'hDEADBEEF;
    entry_vld[3] = 1'b1;
    req_valid[0] = 1'b1; req_index[0] = 5'd3; req_burst[0] = 1'b0; req_len[0] = 5'd9;
    #1 check("t1_ready", {63'd0, req_ready[0]}, 64'd1);
    tick();
    req_valid[0] = 1'b0;
    check("t1_beat", {rsp_valid[0], rsp_data[0], rsp_hit[0], rsp_index[0], rsp_last[0]},
          {1'b1, 32'hDEADBEEF, 1'b1, 5'd3, 1'b1});
    tick();
    check("t1_drop", {63'd0, rsp_valid[0]}, 64'd0);

    // Back-to-back singles at full rate
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        req_valid[0] = 1'b1; req_index[0] = 5'(5 + k); req_burst[0] = 1'b0;
        #1 check("b2b_ready", {63'd0, req_ready[0]}, 64'd1);
      end else begin
        req_valid[0] = 1'b0;
      end
      if (k > 0) check("b2b_beat", {rsp_valid[0], rsp_index[0], rsp_last[0]}, {1'b1, 5'(4 + k), 1'b1});
      tick();
    end
    check("b2b_drop", {63'd0, rsp_valid[0]}, 64'd0);

    // Burst wrapping past the top entry
    req_valid[0] = 1'b1; req_index[0] = 5'd30; req_burst[0] = 1'b1; req_len[0] = 5'd3;
    tick();
    req_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t2_beat", {rsp_valid[0], rsp_index[0], rsp_last[0]}, {1'b1, 5'((30 + k) % 32), k == 3});
      check("t2_busy", {62'd0, busy[0], req_ready[0]}, {62'd0, k < 3, k == 3});
      tick();
    end

    // Burst stalled by the consumer
    req_valid[0] = 1'b1; req_index[0] = 5'd0; req_burst[0] = 1'b1; req_len[0] = 5'd2;
    tick();
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold", {rsp_valid[0], rsp_data[0], rsp_index[0], rsp_last[0], req_ready[0]},
            {1'b1, all_data[31:0], 5'd0, 1'b0, 1'b0});
      if (k < 4) tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    check("t3_beat1", {rsp_valid[0], rsp_index[0], rsp_last[0]}, {1'b1, 5'd1, 1'b0});
    tick();
    check("t3_beat2", {rsp_valid[0], rsp_index[0], rsp_last[0]}, {1'b1, 5'd2, 1'b1});
    tick();
    check("t3_drop", {63'd0, rsp_valid[0]}, 64'd0);

    // Data is taken live at load time, not at request acceptance
    mon_data_en = 1'b0;
    old8 = all_data[8*32 +: 32];
    req_valid[0] = 1'b1; req_index[0] = 5'd8; req_burst[0] = 1'b1; req_len[0] = 5'd2;
    tick();
    req_valid[0] = 1'b0;
    check("live_b0", {32'd0, rsp_data[0]}, {32'd0, old8});
    all_data[8*32 +: 32]  = ~old8;
    all_data[9*32 +: 32]  = 32'h1234_5678;
    all_data[10*32 +: 32] = 32'hCAFE_F00D;
    tick();
    check("live_b1", {rsp_valid[0], rsp_data[0], rsp_index[0]}, {1'b1, 32'h1234_5678, 5'd9});
    tick();
    check("live_b2", {rsp_valid[0], rsp_data[0], rsp_index[0], rsp_last[0]}, {1'b1, 32'hCAFE_F00D, 5'd10, 1'b1});
    tick();
    mon_data_en = 1'b1;

    // Out-of-range start on the DEPTH=20 port
    req_valid[1] = 1'b1; req_index[1] = 5'd25; req_burst[1] = 1'b1; req_len[1] = 5'd5;
    #1 check("t4_ready", {63'd0, req_ready[1]}, 64'd1);
    tick();
    req_valid[1] = 1'b0;
    check("t4_beat", {rsp_valid[1], rsp_data[1], rsp_hit[1], rsp_index[1], rsp_last[1], busy[1]},
          {1'b1, 32'd0, 1'b0, 5'd25, 1'b1, 1'b0});
    tick();
    check("t4_drop", {63'd0, rsp_valid[1]}, 64'd0);

    // Reset mid-burst
    req_valid[0] = 1'b1; req_index[0] = 5'd4; req_burst[0] = 1'b1; req_len[0] = 5'd7;
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("t5_second", {rsp_valid[0], rsp_index[0]}, {1'b1, 5'd5});
    reset = 1'b1;
    tick();
    check("t5_abort", {61'd0, rsp_valid[0], busy[0], req_ready[0]}, 64'd0);
    reset = 1'b0;
    #1 check("t5_ready", {63'd0, req_ready[0]}, 64'd1);
    tick();
    check("t5_quiet", {62'd0, rsp_valid[0], busy[0]}, 64'd0);

    // any_vld follows the OR of each port's own valid bits one cycle later
    entry_vld = 32'h0;
    tick();
    check("any0", {62'd0, any_vld[0], any_vld[1]}, 64'd0);
    entry_vld = 32'h0000_0100;
    tick();
    check("any1", {62'd0, any_vld[0], any_vld[1]}, 64'd3);
    entry_vld = 32'h0200_0000;
    tick();
    check("any_hi", {62'd0, any_vld[0], any_vld[1]}, 64'd2);
    entry_vld = 32'h0;
    tick();
    check("any_off", {62'd0, any_vld[0], any_vld[1]}, 64'd0);

    // Randomized traffic with a backpressuring consumer, entries stable per batch
    for (int d = 0; d < 2; d++) begin
      for (int batch = 0; batch < 3; batch++) begin
        randomize_entries();
        rr_mode[d] = 1'b1;
        for (int r = 0; r < 20; r++) begin
          send(d, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4)));
          if ($urandom_range(0, 3) == 0) idle_req(d);
        end
        idle_req(d);
        drain(d);
        rr_mode[d] = 1'b0;
        @(negedge clk);
        rsp_ready[d] = 1'b1;
      end
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

`default_nettype wire
